// File: rtl/sram_lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the SRAM load/store unit and its writeback-stage
// users: RV32 load/store funct3 codes, response error encodings, the request
// struct, the response-buffer FSM states and the store byte-enable decoder.
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_FUNCT3   = 2'b11
  } lsu_err_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } lsu_state_e;

  // Byte enables for a legal store; lane k is the byte at address+k.
  function automatic logic [3:0] store_wen(input logic [2:0] funct3);
    logic [3:0] wen;
    case (funct3)
      F3_B:    wen = 4'b0001;
      F3_H:    wen = 4'b0011;
      F3_W:    wen = 4'b1111;
      default: wen = 4'b0000;
    endcase
    return wen;
  endfunction

endpackage

// File: rtl/sram_lsu_if.sv
// ---------------------------------------------------------------------------
// sram_lsu_if
// Bundles the MEM-stage request channel, the response channel and the
// byte-lane SRAM port of the load/store unit.
//   req_*  : valid/ready request (we, funct3, addr, wdata)
//   resp_* : valid/ready response (rdata, err)
//   mem_*  : SRAM initiator port (w_en, addr, wdata out; rdata in)
// Modport slave is the LSU side; modport master is the environment side
// (pipeline stage, response consumer and SRAM).
// ---------------------------------------------------------------------------
interface sram_lsu_if #(
  parameter int ADDR_W = 16
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic [1:0]        resp_err;

  logic [3:0]        mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_w_en, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_w_en, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/sram_lsu_extend.sv
// ---------------------------------------------------------------------------
// lsu_extend
// Combinational load extender, shared with the writeback stage.
//   funct3 : load width/signedness (B, H, W, BU, HU)
//   rdata  : raw SRAM word, addressed byte in lane 0
//   result : sign/zero-extended value, 0 for codes that are not loads
// ---------------------------------------------------------------------------
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  // Select and extend the addressed lanes.
  always_comb begin
    result = 32'd0;
    case (funct3)
      F3_B:    result = {{24{rdata[7]}}, rdata[7:0]};
      F3_BU:   result = {24'd0, rdata[7:0]};
      F3_H:    result = {{16{rdata[15]}}, rdata[15:0]};
      F3_HU:   result = {16'd0, rdata[15:0]};
      F3_W:    result = rdata;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/sram_lsu.sv
// ---------------------------------------------------------------------------
// sram_lsu
// RV32 load/store unit driving a byte-lane SRAM that reads combinationally
// and writes on the clock edge. Every legal access completes in the cycle it
// is accepted; the result (or fault) is parked in a one-entry response buffer.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : sram_lsu_if.slave (request, response and SRAM port)
// ---------------------------------------------------------------------------
module sram_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  sram_lsu_if.slave  bus
);

  lsu_req_t    req_s;
  lsu_state_e  state_r;
  lsu_state_e  state_next_s;
  logic [31:0] resp_rdata_r;
  logic [31:0] rdata_next_s;
  lsu_err_e    resp_err_r;
  lsu_err_e    err_next_s;
  lsu_err_e    err_s;
  logic        f3_legal_s;
  logic        misaligned_s;
  logic        out_of_range_s;
  logic        req_ready_s;
  logic        accept_s;
  logic [31:0] ext_s;

  assign req_s = '{we:     bus.req_we,
                   funct3: bus.req_funct3,
                   addr:   bus.req_addr,
                   wdata:  bus.req_wdata};

  // A held response that drains this cycle frees the buffer for a new request.
  assign req_ready_s = (state_r == ST_EMPTY) || bus.resp_ready;
  // Reset gates acceptance so nothing is written while rst_n is low.
  assign accept_s    = bus.req_valid && req_ready_s && rst_n;

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = (state_r == ST_FULL);
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.mem_addr   = req_s.addr[ADDR_W-1:0];
  assign bus.mem_wdata  = req_s.wdata;

  // Decode funct3 legality and alignment; unsigned widths are load-only.
  always_comb begin
    f3_legal_s   = 1'b0;
    misaligned_s = 1'b0;
    case (req_s.funct3)
      F3_B: begin
        f3_legal_s   = 1'b1;
        misaligned_s = 1'b0;
      end
      F3_BU: begin
        f3_legal_s   = !req_s.we;
        misaligned_s = 1'b0;
      end
      F3_H: begin
        f3_legal_s   = 1'b1;
        misaligned_s = req_s.addr[0];
      end
      F3_HU: begin
        f3_legal_s   = !req_s.we;
        misaligned_s = req_s.addr[0];
      end
      F3_W: begin
        f3_legal_s   = 1'b1;
        misaligned_s = (req_s.addr[1:0] != 2'b00);
      end
      default: begin
        f3_legal_s   = 1'b0;
        misaligned_s = 1'b0;
      end
    endcase
  end

  // No wrap: any address bit above the SRAM window is a range fault.
  assign out_of_range_s = ((req_s.addr >> ADDR_W) != 32'd0);

  // Fault priority: funct3, then range, then alignment.
  always_comb begin
    err_s = ERR_OK;
    if (!f3_legal_s) begin
      err_s = ERR_FUNCT3;
    end else if (out_of_range_s) begin
      err_s = ERR_RANGE;
    end else if (misaligned_s) begin
      err_s = ERR_MISALIGN;
    end else begin
      err_s = ERR_OK;
    end
  end

  // Byte enables only for a legal store that is actually accepted.
  always_comb begin
    bus.mem_w_en = 4'b0000;
    if (accept_s && req_s.we && (err_s == ERR_OK)) begin
      bus.mem_w_en = store_wen(req_s.funct3);
    end else begin
      bus.mem_w_en = 4'b0000;
    end
  end

  lsu_extend u_extend (
    .funct3 (req_s.funct3),
    .rdata  (bus.mem_rdata),
    .result (ext_s)
  );

  // Response buffer next state: reload on accept, else drain on resp_ready.
  always_comb begin
    state_next_s = state_r;
    rdata_next_s = resp_rdata_r;
    err_next_s   = resp_err_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_next_s = ST_FULL;
          rdata_next_s = (!req_s.we && (err_s == ERR_OK)) ? ext_s : 32'd0;
          err_next_s   = err_s;
        end else begin
          state_next_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (accept_s) begin
          state_next_s = ST_FULL;
          rdata_next_s = (!req_s.we && (err_s == ERR_OK)) ? ext_s : 32'd0;
          err_next_s   = err_s;
        end else if (bus.resp_ready) begin
          state_next_s = ST_EMPTY;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: begin
        state_next_s = ST_EMPTY;
        rdata_next_s = 32'd0;
        err_next_s   = ERR_OK;
      end
    endcase
  end

  // State and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_EMPTY;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= ERR_OK;
    end else begin
      state_r      <= state_next_s;
      resp_rdata_r <= rdata_next_s;
      resp_err_r   <= err_next_s;
    end
  end

endmodule

// File: tb/tb_sram_lsu.sv
// ---------------------------------------------------------------------------
// tb_sram_lsu
// Self-checking bench for sram_lsu with a byte-addressed SRAM model.
// Expected responses are queued when a request is driven and compared when
// the DUT hands a response over.
// ---------------------------------------------------------------------------
module tb_sram_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sram_lsu_if #(.ADDR_W(16)) bus ();

  sram_lsu #(.ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // SRAM model: combinational read, byte-lane write on the rising edge.
  logic [7:0] mem [0:65535];

  always_comb begin
    bus.mem_rdata = {mem[bus.mem_addr + 16'd3], mem[bus.mem_addr + 16'd2],
                     mem[bus.mem_addr + 16'd1], mem[bus.mem_addr]};
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (bus.mem_w_en[k]) mem[bus.mem_addr + 16'(k)] <= bus.mem_wdata[8*k +: 8];
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Response monitor: one-cycle latency after each accept, scoreboard on handover.
  logic acc_prev = 1'b0;
  always @(negedge clk) begin
    logic [33:0] exp;
    if (acc_prev) check("latency", 64'(bus.resp_valid), 64'd1);
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'(sb_q.size()), 64'd1);
      end else begin
        exp = sb_q.pop_front();
        check("resp", 64'({bus.resp_err, bus.resp_rdata}), 64'(exp));
      end
    end
    acc_prev <= rst_n && bus.req_valid && bus.req_ready;
  end

  task automatic drive(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  // One request expected to be accepted in the cycle it is presented.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] exp_wen,
                        input logic [1:0] exp_err, input logic [31:0] exp_rdata);
    logic [31:0] a;
    a = addr;
    drive(we, f3, addr, wdata);
    @(negedge clk);
    check("req_ready", 64'(bus.req_ready), 64'd1);
    check("w_en", 64'(bus.mem_w_en), 64'(exp_wen));
    check("mem_addr", 64'(bus.mem_addr), 64'(a[15:0]));
    sb_q.push_back({exp_err, exp_rdata});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.resp_ready = 1'b1;

    // Reset with a store presented: no accept, no write.
    drive(1'b1, 3'b010, 32'h0000_0010, 32'hAAAA_AAAA);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_rdata", 64'(bus.resp_rdata), 64'd0);
    check("rst_err", 64'(bus.resp_err), 64'd0);
    check("rst_wen", 64'(bus.mem_w_en), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_valid = 1'b0;

    // Store word then load back.
    do_req(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 2'b00, 32'h0);
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'h0, 4'b0000, 2'b00, 32'hDEAD_BEEF);

    // Extension of 0x000080F0.
    do_req(1'b1, 3'b010, 32'h0000_0020, 32'h0000_80F0, 4'b1111, 2'b00, 32'h0);
    do_req(1'b0, 3'b000, 32'h0000_0020, 32'h0, 4'b0000, 2'b00, 32'hFFFF_FFF0);
    do_req(1'b0, 3'b100, 32'h0000_0020, 32'h0, 4'b0000, 2'b00, 32'h0000_00F0);
    do_req(1'b0, 3'b001, 32'h0000_0020, 32'h0, 4'b0000, 2'b00, 32'hFFFF_80F0);
    do_req(1'b0, 3'b101, 32'h0000_0020, 32'h0, 4'b0000, 2'b00, 32'h0000_80F0);

    // Faults.
    do_req(1'b1, 3'b010, 32'h0000_0030, 32'h1234_5678, 4'b1111, 2'b00, 32'h0);
    do_req(1'b1, 3'b001, 32'h0000_0031, 32'h0000_BEEF, 4'b0000, 2'b01, 32'h0);
    do_req(1'b0, 3'b010, 32'h0000_0030, 32'h0, 4'b0000, 2'b00, 32'h1234_5678);
    do_req(1'b0, 3'b010, 32'h0001_0000, 32'h0, 4'b0000, 2'b10, 32'h0);
    do_req(1'b1, 3'b010, 32'h0001_0000, 32'h5555_5555, 4'b0000, 2'b10, 32'h0);
    do_req(1'b0, 3'b011, 32'h0000_0010, 32'h0, 4'b0000, 2'b11, 32'h0);
    do_req(1'b1, 3'b100, 32'h0000_0010, 32'h0, 4'b0000, 2'b11, 32'h0);
    do_req(1'b0, 3'b011, 32'h0001_0001, 32'h0, 4'b0000, 2'b11, 32'h0);
    do_req(1'b0, 3'b010, 32'h0001_0001, 32'h0, 4'b0000, 2'b10, 32'h0);
    do_req(1'b0, 3'b101, 32'h0000_0023, 32'h0, 4'b0000, 2'b01, 32'h0);

    // Top word of the SRAM is legal.
    do_req(1'b1, 3'b010, 32'h0000_FFFC, 32'hCAFE_F00D, 4'b1111, 2'b00, 32'h0);
    do_req(1'b0, 3'b010, 32'h0000_FFFC, 32'h0, 4'b0000, 2'b00, 32'hCAFE_F00D);

    // Sub-word stores merge into existing words.
    do_req(1'b1, 3'b010, 32'h0000_0040, 32'h1122_3344, 4'b1111, 2'b00, 32'h0);
    do_req(1'b1, 3'b000, 32'h0000_0042, 32'h0000_005A, 4'b0001, 2'b00, 32'h0);
    do_req(1'b0, 3'b010, 32'h0000_0040, 32'h0, 4'b0000, 2'b00, 32'h115A_3344);
    do_req(1'b1, 3'b010, 32'h0000_0044, 32'h5566_7788, 4'b1111, 2'b00, 32'h0);
    do_req(1'b1, 3'b001, 32'h0000_0046, 32'h0000_ABCD, 4'b0011, 2'b00, 32'h0);
    do_req(1'b0, 3'b010, 32'h0000_0044, 32'h0, 4'b0000, 2'b00, 32'hABCD_7788);

    // Back-pressure: response held, next store blocked for 3 cycles.
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'h0, 4'b0000, 2'b00, 32'hDEAD_BEEF);
    drive(1'b1, 3'b010, 32'h0000_0010, 32'h7777_7777);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", 64'(bus.req_ready), 64'd0);
      check("bp_wen", 64'(bus.mem_w_en), 64'd0);
      check("bp_valid", 64'(bus.resp_valid), 64'd1);
      check("bp_hold", 64'({bus.resp_err, bus.resp_rdata}), 64'h0_DEAD_BEEF);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("drain_ready", 64'(bus.req_ready), 64'd1);
    check("drain_wen", 64'(bus.mem_w_en), 64'hF);
    sb_q.push_back({2'b00, 32'h0});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'h0, 4'b0000, 2'b00, 32'h7777_7777);

    // Reset mid-operation with a store pending.
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'h0, 4'b0000, 2'b00, 32'h7777_7777);
    sb_q.delete();
    rst_n = 1'b0;
    drive(1'b1, 3'b010, 32'h0000_0010, 32'h9999_9999);
    @(negedge clk);
    check("mrst_wen0", 64'(bus.mem_w_en), 64'd0);
    check("mrst_pend", 64'(bus.resp_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("mrst_valid", 64'(bus.resp_valid), 64'd0);
    check("mrst_rdata", 64'(bus.resp_rdata), 64'd0);
    check("mrst_wen1", 64'(bus.mem_w_en), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'h0, 4'b0000, 2'b00, 32'h7777_7777);

    repeat (3) @(negedge clk);
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_lsu.md
# sram_lsu

Load/store unit that acts as the initiator on the byte-lane SRAM port (`w_en[3:0]`, `address[15:0]`, `write_data`, `read_data`). It accepts RV32 load/store requests from the MEM pipeline stage through a valid/ready handshake. It checks alignment and range, drives byte enables, and returns sign- or zero-extended load data or a fault through a registered one-entry response buffer. The SRAM reads combinationally and writes on the clock edge, so every legal access completes in the accept cycle.

## Interface
- `ADDR_W`, 16: SRAM byte-address width. Higher request address bits must be zero.
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: request accepted when `req_valid && req_ready`.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: 000 B, 001 H, 010 W, 100 BU, 101 HU. Other values are illegal.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data, right-aligned.
- `resp_valid`  out  1: response held.
- `resp_ready`  in  1: consumer takes the response.
- `resp_rdata`  out  32: extended load data. 0 for stores and faults.
- `resp_err`  out  2: 00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.
- `mem_w_en`  out  4: SRAM byte write enables.
- `mem_addr`  out  `ADDR_W`: SRAM address. Equals `req_addr[ADDR_W-1:0]`.
- `mem_wdata`  out  32: equals `req_wdata` (lane k = byte at address+k).
- `mem_rdata`  in  32: SRAM read data (combinational).

## Operation
- Two-state FSM: EMPTY and FULL (`resp_valid`).
- `req_ready = !resp_valid || resp_ready`. A new request may be accepted in the same cycle the held response drains.
- Fault priority: illegal funct3 > out of range (`req_addr[31:ADDR_W] != 0`) > misaligned (H/HU with `addr[0]`; W with `addr[1:0] != 0`).
- Byte enables are combinational. They are nonzero only when accepting a legal store and `rst_n` = 1: B → 0001, H → 0011, W → 1111. BU and HU stores count as illegal funct3.
- Loads, faults, idle cycles, and reset all drive `mem_w_en` = 0000. A faulting store never writes.
- Load extension from `mem_rdata`:
  - B: sign-extend [7:0]. BU: zero-extend [7:0].
  - H: sign-extend [15:0]. HU: zero-extend [15:0].
  - W: pass through.
- On accept, capture the result into the `resp_*` registers and enter FULL.
- Leave FULL on `resp_ready`, unless a new request is accepted in the same cycle. In that case the buffer reloads and the FSM stays FULL.
- While FULL without `resp_ready`, the `resp_*` outputs are held stable.

## Timing
- Reset values: `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 00, FSM = EMPTY. `mem_w_en` = 0000 while `rst_n` = 0.
- Latency: a request accepted at edge N has its response visible after edge N, so `resp_valid` = 1 in cycle N+1. Store data is in the SRAM after edge N.
- Throughput: one access per cycle when `resp_ready` is held high.
- Back-pressure: while `resp_valid && !resp_ready`, `req_ready` = 0 and no SRAM write occurs.
- Reset mid-operation: a pending response is discarded. A request presented during reset is not accepted and causes no write.
- Load-after-store to the same address in consecutive accepts returns the new data, because the SRAM write lands at the first edge.
- Address wrap: none. The range check rejects addresses at or above 2^`ADDR_W`. Word address 0xFFFC is legal.

## Structure
- Shared package `lsu_pkg` holds:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the `resp_err` encodings;
  - a `lsu_req_t` struct.
- Sub-module `lsu_extend`: combinational load extender (funct3, rdata → 32-bit result). It is reused by the writeback stage.

## Test plan
- Store word then load: SW 0xDEADBEEF @0x0010, then LW @0x0010 → `mem_w_en` = 1111, then `resp_rdata` = 0xDEADBEEF, `resp_err` = 00, each response one cycle after accept.
- Extension: memory word 0x0000_80F0 @0x0020 → LB = 0xFFFFFFF0, LBU = 0x000000F0, LH = 0xFFFF80F0, LHU = 0x000080F0.
- Faults:
  - SH @0x0031 → `resp_err` = 01, `mem_w_en` = 0000, and the following LW @0x0030 shows memory unchanged.
  - LW @0x0001_0000 → `resp_err` = 10.
  - funct3 = 011 → `resp_err` = 11.
- Back-pressure: hold `resp_ready` = 0 for 3 cycles with `req_valid` = 1 → `req_ready` = 0 and outputs stable. Raise `resp_ready` → drain and accept in the same cycle, `resp_valid` stays 1.
- Byte store: SB 0x5A @0x0042 over word 0x11223344 @0x0040 → `mem_w_en` = 0001; LW @0x0040 = 0x115A3344.
- Reset mid-operation: drop `rst_n` with `resp_valid` = 1 and a store request pending → next cycle `resp_valid` = 0, no write, memory unchanged.
